// File: rtl/br_cond_arbiter_if.sv
// Bus bundle for br_cond_arbiter.
//
// Carries the two request channels (valid/ready plus operands, branch type and
// tag) and the single response channel (valid/ready plus taken, src, tag).
//   master : requester and consumer side (drives requests and resp_ready)
//   slave  : arbiter side (drives request readies and the response fields)
// Clock and reset are not part of the bundle; they stay plain module ports.
interface br_cond_arbiter_if #(
  parameter int unsigned TAG_W = 4
) ();

  // Requester 0
  logic             io_req0_valid;
  logic             io_req0_ready;
  logic [31:0]      io_req0_rs1;
  logic [31:0]      io_req0_rs2;
  logic [2:0]       io_req0_br_type;
  logic [TAG_W-1:0] io_req0_tag;

  // Requester 1
  logic             io_req1_valid;
  logic             io_req1_ready;
  logic [31:0]      io_req1_rs1;
  logic [31:0]      io_req1_rs2;
  logic [2:0]       io_req1_br_type;
  logic [TAG_W-1:0] io_req1_tag;

  // Response
  logic             io_resp_valid;
  logic             io_resp_ready;
  logic             io_resp_taken;
  logic             io_resp_src;
  logic [TAG_W-1:0] io_resp_tag;

  modport master (
    output io_req0_valid, io_req0_rs1, io_req0_rs2, io_req0_br_type, io_req0_tag,
    input  io_req0_ready,
    output io_req1_valid, io_req1_rs1, io_req1_rs2, io_req1_br_type, io_req1_tag,
    input  io_req1_ready,
    input  io_resp_valid, io_resp_taken, io_resp_src, io_resp_tag,
    output io_resp_ready
  );

  modport slave (
    input  io_req0_valid, io_req0_rs1, io_req0_rs2, io_req0_br_type, io_req0_tag,
    output io_req0_ready,
    input  io_req1_valid, io_req1_rs1, io_req1_rs2, io_req1_br_type, io_req1_tag,
    output io_req1_ready,
    output io_resp_valid, io_resp_taken, io_resp_src, io_resp_tag,
    input  io_resp_ready
  );

endinterface

// File: rtl/br_cond_arbiter.sv
// Two-requester branch-condition arbiter.
//
// Two requesters share a single branch-compare datapath. A round-robin grant
// (one-bit priority pointer) picks at most one request per cycle whenever the
// one-entry output register is free or being drained in the same cycle. The
// compare result, winning index and requester tag appear on the response one
// cycle after the handshake.
//
// Ports:
//   clock             : clock, all state updates on the rising edge
//   reset             : synchronous, active-high reset
//   bus (slave)       : request channels 0/1 and the response channel
//   io_perf_branches  : handshake count (only with BR_COND_ARB_PERF_EN)
//   io_perf_taken     : taken-handshake count (only with BR_COND_ARB_PERF_EN)
//
// Optional feature macro: BR_COND_ARB_PERF_EN adds the two 32-bit wrapping
// performance counters and their output ports.
//
// Branch type encoding: 3=EQ, 6=NE, 2=LT, 5=GE, 1=LTU, 4=GEU, 0/7 never taken.
module br_cond_arbiter #(
  parameter int unsigned TAG_W = 4
) (
  input  logic        clock,
  input  logic        reset,
  br_cond_arbiter_if.slave bus
`ifdef BR_COND_ARB_PERF_EN
  ,
  output logic [31:0] io_perf_branches,
  output logic [31:0] io_perf_taken
`endif
);

  localparam logic [2:0] BrLtu = 3'd1;
  localparam logic [2:0] BrLt  = 3'd2;
  localparam logic [2:0] BrEq  = 3'd3;
  localparam logic [2:0] BrGeu = 3'd4;
  localparam logic [2:0] BrGe  = 3'd5;
  localparam logic [2:0] BrNe  = 3'd6;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             resp_valid_q, resp_valid_d;
  logic             resp_taken_q, resp_taken_d;
  logic             resp_src_q,   resp_src_d;
  logic [TAG_W-1:0] resp_tag_q,   resp_tag_d;
  logic             prio_q,       prio_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic slot_free;
  logic grant0;
  logic grant1;
  logic hs;
  logic sel;

  // The slot can take a new entry when empty or when the held entry leaves now.
  assign slot_free = ~resp_valid_q | bus.io_resp_ready;

  // Requester prio wins if valid, otherwise the other one. Readies are forced
  // low in a reset cycle so nothing is accepted while state is being cleared.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset && slot_free) begin
      if (prio_q) begin
        grant1 = bus.io_req1_valid;
        grant0 = bus.io_req0_valid & ~bus.io_req1_valid;
      end else begin
        grant0 = bus.io_req0_valid;
        grant1 = bus.io_req1_valid & ~bus.io_req0_valid;
      end
    end
  end

  assign bus.io_req0_ready = grant0;
  assign bus.io_req1_ready = grant1;

  // A grant is only ever given to a valid requester, so grant == handshake.
  assign hs  = grant0 | grant1;
  assign sel = grant1;

  // ---------------------------------------------------------------------------
  // Shared compare datapath
  // ---------------------------------------------------------------------------
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [2:0]       op_type;
  logic [TAG_W-1:0] op_tag;

  assign op_a    = sel ? bus.io_req1_rs1     : bus.io_req0_rs1;
  assign op_b    = sel ? bus.io_req1_rs2     : bus.io_req0_rs2;
  assign op_type = sel ? bus.io_req1_br_type : bus.io_req0_br_type;
  assign op_tag  = sel ? bus.io_req1_tag     : bus.io_req0_tag;

  logic [31:0] diff;
  logic        same_sign;
  logic        cmp_eq;
  logic        cmp_lt;
  logic        cmp_ltu;
  logic        cmp_taken;

  // With equal sign bits the subtraction cannot overflow, so diff[31] is the
  // answer; with differing signs the operand signs decide directly.
  assign diff      = op_a - op_b;
  assign same_sign = (op_a[31] == op_b[31]);
  assign cmp_eq    = (diff == 32'd0);
  assign cmp_lt    = same_sign ? diff[31] : op_a[31];
  assign cmp_ltu   = same_sign ? diff[31] : op_b[31];

  always_comb begin
    cmp_taken = 1'b0;
    case (op_type)
      BrEq:    cmp_taken = cmp_eq;
      BrNe:    cmp_taken = ~cmp_eq;
      BrLt:    cmp_taken = cmp_lt;
      BrGe:    cmp_taken = ~cmp_lt;
      BrLtu:   cmp_taken = cmp_ltu;
      BrGeu:   cmp_taken = ~cmp_ltu;
      default: cmp_taken = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register and priority pointer
  // ---------------------------------------------------------------------------
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_taken_d = resp_taken_q;
    resp_src_d   = resp_src_q;
    resp_tag_d   = resp_tag_q;
    prio_d       = prio_q;
    if (hs) begin
      // Covers both filling an empty slot and replacing a draining entry.
      resp_valid_d = 1'b1;
      resp_taken_d = cmp_taken;
      resp_src_d   = sel;
      resp_tag_d   = op_tag;
      prio_d       = ~sel;
    end else if (bus.io_resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_taken_q <= 1'b0;
      resp_src_q   <= 1'b0;
      resp_tag_q   <= '0;
      prio_q       <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_taken_q <= resp_taken_d;
      resp_src_q   <= resp_src_d;
      resp_tag_q   <= resp_tag_d;
      prio_q       <= prio_d;
    end
  end

  assign bus.io_resp_valid = resp_valid_q;
  assign bus.io_resp_taken = resp_taken_q;
  assign bus.io_resp_src   = resp_src_q;
  assign bus.io_resp_tag   = resp_tag_q;

  // ---------------------------------------------------------------------------
  // Optional performance counters
  // ---------------------------------------------------------------------------
`ifdef BR_COND_ARB_PERF_EN
  logic [31:0] perf_br_q, perf_br_d;
  logic [31:0] perf_tk_q, perf_tk_d;

  // Both counters wrap naturally at 2^32.
  always_comb begin
    perf_br_d = perf_br_q;
    perf_tk_d = perf_tk_q;
    if (hs) begin
      perf_br_d = perf_br_q + 32'd1;
      if (cmp_taken) begin
        perf_tk_d = perf_tk_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_br_q <= 32'd0;
      perf_tk_q <= 32'd0;
    end else begin
      perf_br_q <= perf_br_d;
      perf_tk_q <= perf_tk_d;
    end
  end

  assign io_perf_branches = perf_br_q;
  assign io_perf_taken    = perf_tk_q;
`endif

endmodule

// File: tb/tb_br_cond_arbiter.sv
module tb_br_cond_arbiter;

  localparam int unsigned TAG_W = 4;

  logic clock;
  logic reset;

  br_cond_arbiter_if #(.TAG_W(TAG_W)) bus ();

`ifdef BR_COND_ARB_PERF_EN
  logic [31:0] perf_branches;
  logic [31:0] perf_taken;
`endif

  br_cond_arbiter #(.TAG_W(TAG_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .bus              (bus.slave)
`ifdef BR_COND_ARB_PERF_EN
    ,
    .io_perf_branches (perf_branches),
    .io_perf_taken    (perf_taken)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int total = 0;
  int bad   = 0;

  // Scoreboard entry: {taken, src, tag}
  logic [TAG_W+1:0] sb[$];

  // Reference compare written from the signed/unsigned meaning of each type.
  function automatic logic ref_taken(input logic [31:0] a, input logic [31:0] b,
                                     input logic [2:0] t);
    case (t)
      3'd3:    return a == b;
      3'd6:    return a != b;
      3'd2:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd1:    return a < b;
      3'd4:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Advance to just after the rising edge (drive point).
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Advance to the falling edge (sample point).
  task automatic mid();
    @(negedge clock);
  endtask

  task automatic drive_req(input int n, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] t,
                           input logic [TAG_W-1:0] tag);
    if (n == 0) begin
      bus.io_req0_valid = v; bus.io_req0_rs1 = a; bus.io_req0_rs2 = b;
      bus.io_req0_br_type = t; bus.io_req0_tag = tag;
    end else begin
      bus.io_req1_valid = v; bus.io_req1_rs1 = a; bus.io_req1_rs2 = b;
      bus.io_req1_br_type = t; bus.io_req1_tag = tag;
    end
  endtask

  task automatic idle_reqs();
    bus.io_req0_valid = 1'b0;
    bus.io_req1_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [TAG_W+2:0] obs;
    cyc();
    reset = 1'b1;
    drive_req(0, 1'b1, 32'd1, 32'd1, 3'd3, 4'd1);
    drive_req(1, 1'b1, 32'd1, 32'd1, 3'd3, 4'd2);
    bus.io_resp_ready = 1'b1;
    mid();
    total++;
    if ({bus.io_req0_ready, bus.io_req1_ready} !== 2'b00) begin
      bad++;
      $display("FAIL reset_ready: got %b expected 00",
               {bus.io_req0_ready, bus.io_req1_ready});
    end
    cyc();
    mid();
    obs = {bus.io_resp_valid, bus.io_resp_taken, bus.io_resp_src, bus.io_resp_tag};
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL reset_resp: got %h expected 0", obs);
    end
    cyc();
    reset = 1'b0;
    idle_reqs();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single();
    logic [TAG_W+1:0] exp;
    cyc();
    drive_req(0, 1'b1, 32'd5, 32'd5, 3'd3, 4'd2);
    bus.io_resp_ready = 1'b1;
    sb.push_back({1'b1, 1'b0, 4'd2});
    mid();
    total++;
    if ({bus.io_req0_ready, bus.io_req1_ready} !== 2'b10) begin
      bad++;
      $display("FAIL single_ready: got %b expected 10",
               {bus.io_req0_ready, bus.io_req1_ready});
    end
    cyc();
    idle_reqs();
    mid();
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL single_sb: scoreboard empty");
    end else begin
      exp = sb.pop_front();
      if ({bus.io_resp_valid, bus.io_resp_taken, bus.io_resp_src, bus.io_resp_tag}
          !== {1'b1, exp}) begin
        bad++;
        $display("FAIL single_resp: got v=%b t=%b s=%b tag=%h expected v=1 t=%b s=%b tag=%h",
                 bus.io_resp_valid, bus.io_resp_taken, bus.io_resp_src, bus.io_resp_tag,
                 exp[TAG_W+1], exp[TAG_W], exp[TAG_W-1:0]);
      end
    end
    cyc();
    mid();
    total++;
    if (bus.io_resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_drain: resp_valid=%b expected 0", bus.io_resp_valid);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_compare();
    logic [31:0] ta[16];
    logic [31:0] tb_[16];
    logic [2:0]  tt[16];
    logic [TAG_W+1:0] exp;
    ta  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'd5, 32'd3, 32'd7, 32'h8000_0000, 32'h8000_0000, 32'd1,
            32'd0, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
    tb_ = '{32'd1, 32'd1, 32'd1, 32'd1,
            32'd5, 32'd7, 32'd3, 32'd1, 32'd1, 32'h8000_0000,
            32'd0, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 32'd0};
    tt  = '{3'd2, 3'd1, 3'd4, 3'd7,
            3'd6, 3'd2, 3'd5, 3'd2, 3'd1, 3'd4,
            3'd0, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0};
    // Last entries are random operands and types.
    for (int i = 12; i < 16; i++) begin
      ta[i]  = $urandom;
      tb_[i] = (i == 12) ? ta[i] : $urandom;
      tt[i]  = 3'($urandom_range(7, 0));
    end
    bus.io_resp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      drive_req(i % 2, 1'b1, ta[i], tb_[i], tt[i], 4'(i));
      sb.push_back({ref_taken(ta[i], tb_[i], tt[i]), 1'(i % 2), 4'(i)});
      cyc();
      idle_reqs();
      mid();
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL cmp_sb[%0d]: scoreboard empty", i);
      end else begin
        exp = sb.pop_front();
        if ({bus.io_resp_valid, bus.io_resp_taken, bus.io_resp_src, bus.io_resp_tag}
            !== {1'b1, exp}) begin
          bad++;
          $display("FAIL cmp[%0d] a=%h b=%h t=%0d: got v=%b t=%b s=%b tag=%h expected v=1 t=%b s=%b tag=%h",
                   i, ta[i], tb_[i], tt[i], bus.io_resp_valid, bus.io_resp_taken,
                   bus.io_resp_src, bus.io_resp_tag, exp[TAG_W+1], exp[TAG_W], exp[TAG_W-1:0]);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_round_robin();
    logic [TAG_W+1:0] exp;
    logic [1:0] exp_rdy;
    cyc();
    reset = 1'b1;
    idle_reqs();
    cyc();
    reset = 1'b0;
    bus.io_resp_ready = 1'b1;
    // req0: EQ on equal operands (taken); req1: EQ on unequal operands (not taken)
    drive_req(0, 1'b1, 32'd1, 32'd1, 3'd3, 4'hA);
    drive_req(1, 1'b1, 32'd1, 32'd2, 3'd3, 4'hB);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        sb.push_back((i % 2 == 0) ? {1'b1, 1'b0, 4'hA} : {1'b0, 1'b1, 4'hB});
      end else begin
        idle_reqs();
      end
      mid();
      if (i < 4) begin
        exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
        total++;
        if ({bus.io_req0_ready, bus.io_req1_ready} !== exp_rdy) begin
          bad++;
          $display("FAIL rr_grant[%0d]: got %b expected %b", i,
                   {bus.io_req0_ready, bus.io_req1_ready}, exp_rdy);
        end
      end
      if (i > 0) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL rr_sb[%0d]: scoreboard empty", i);
        end else begin
          exp = sb.pop_front();
          if ({bus.io_resp_valid, bus.io_resp_taken, bus.io_resp_src, bus.io_resp_tag}
              !== {1'b1, exp}) begin
            bad++;
            $display("FAIL rr_resp[%0d]: got v=%b t=%b s=%b tag=%h expected v=1 t=%b s=%b tag=%h",
                     i, bus.io_resp_valid, bus.io_resp_taken, bus.io_resp_src, bus.io_resp_tag,
                     exp[TAG_W+1], exp[TAG_W], exp[TAG_W-1:0]);
          end
        end
      end
      cyc();
    end
    idle_reqs();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    logic [TAG_W+1:0] exp;
    cyc();
    bus.io_resp_ready = 1'b0;
    drive_req(0, 1'b1, 32'd9, 32'd9, 3'd3, 4'd3);
    sb.push_back({1'b1, 1'b0, 4'd3});
    mid();
    total++;
    if ({bus.io_req0_ready, bus.io_req1_ready} !== 2'b10) begin
      bad++;
      $display("FAIL bp_first_grant: got %b expected 10",
               {bus.io_req0_ready, bus.io_req1_ready});
    end
    cyc();
    drive_req(0, 1'b1, 32'd1, 32'd2, 3'd1, 4'd4);
    drive_req(1, 1'b1, 32'd2, 32'd1, 3'd6, 4'd5);
    for (int i = 0; i < 3; i++) begin
      mid();
      total++;
      if ({bus.io_req0_ready, bus.io_req1_ready} !== 2'b00) begin
        bad++;
        $display("FAIL bp_hold_ready[%0d]: got %b expected 00", i,
                 {bus.io_req0_ready, bus.io_req1_ready});
      end
      total++;
      if ({bus.io_resp_valid, bus.io_resp_taken, bus.io_resp_src, bus.io_resp_tag}
          !== {1'b1, sb[0]}) begin
        bad++;
        $display("FAIL bp_hold_resp[%0d]: got v=%b t=%b s=%b tag=%h expected v=1 t=1 s=0 tag=3",
                 i, bus.io_resp_valid, bus.io_resp_taken, bus.io_resp_src, bus.io_resp_tag);
      end
      cyc();
    end
    bus.io_resp_ready = 1'b1;
    // prio points at requester 1 after the first handshake
    sb.push_back({1'b1, 1'b1, 4'd5});
    mid();
    total++;
    if ({bus.io_req0_ready, bus.io_req1_ready} !== 2'b01) begin
      bad++;
      $display("FAIL bp_drain_grant: got %b expected 01",
               {bus.io_req0_ready, bus.io_req1_ready});
    end
    for (int i = 0; i < 2; i++) begin
      if (i == 1) mid();
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL bp_sb[%0d]: scoreboard empty", i);
      end else begin
        exp = sb.pop_front();
        if ({bus.io_resp_valid, bus.io_resp_taken, bus.io_resp_src, bus.io_resp_tag}
            !== {1'b1, exp}) begin
          bad++;
          $display("FAIL bp_resp[%0d]: got v=%b t=%b s=%b tag=%h expected v=1 t=%b s=%b tag=%h",
                   i, bus.io_resp_valid, bus.io_resp_taken, bus.io_resp_src, bus.io_resp_tag,
                   exp[TAG_W+1], exp[TAG_W], exp[TAG_W-1:0]);
        end
      end
      if (i == 0) begin
        cyc();
        idle_reqs();
      end
    end
    cyc();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    logic [TAG_W+1:0] exp;
    logic [TAG_W+2:0] obs;
    cyc();
    bus.io_resp_ready = 1'b0;
    drive_req(0, 1'b1, 32'd4, 32'd4, 3'd3, 4'd6);
    sb.push_back({1'b1, 1'b0, 4'd6});
    cyc();
    // entry now held and prio points at requester 1
    reset = 1'b1;
    drive_req(0, 1'b1, 32'd8, 32'd8, 3'd5, 4'd7);
    drive_req(1, 1'b1, 32'd8, 32'd8, 3'd5, 4'd8);
    mid();
    total++;
    if (bus.io_resp_valid !== 1'b1) begin
      bad++;
      $display("FAIL rmid_held: resp_valid=%b expected 1", bus.io_resp_valid);
    end
    total++;
    if ({bus.io_req0_ready, bus.io_req1_ready} !== 2'b00) begin
      bad++;
      $display("FAIL rmid_ready: got %b expected 00", {bus.io_req0_ready, bus.io_req1_ready});
    end
    cyc();
    reset = 1'b0;
    bus.io_resp_ready = 1'b1;
    void'(sb.pop_front());  // held entry is discarded by reset
    sb.push_back({1'b1, 1'b0, 4'd7});
    mid();
    obs = {bus.io_resp_valid, bus.io_resp_taken, bus.io_resp_src, bus.io_resp_tag};
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL rmid_cleared: got %h expected 0", obs);
    end
    total++;
    if ({bus.io_req0_ready, bus.io_req1_ready} !== 2'b10) begin
      bad++;
      $display("FAIL rmid_prio: got %b expected 10", {bus.io_req0_ready, bus.io_req1_ready});
    end
`ifdef BR_COND_ARB_PERF_EN
    total++;
    if ({perf_branches, perf_taken} !== 64'd0) begin
      bad++;
      $display("FAIL rmid_perf: got br=%0d tk=%0d expected 0 0", perf_branches, perf_taken);
    end
`endif
    cyc();
    idle_reqs();
    mid();
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL rmid_sb: scoreboard empty");
    end else begin
      exp = sb.pop_front();
      if ({bus.io_resp_valid, bus.io_resp_taken, bus.io_resp_src, bus.io_resp_tag}
          !== {1'b1, exp}) begin
        bad++;
        $display("FAIL rmid_resp: got v=%b t=%b s=%b tag=%h expected v=1 t=%b s=%b tag=%h",
                 bus.io_resp_valid, bus.io_resp_taken, bus.io_resp_src, bus.io_resp_tag,
                 exp[TAG_W+1], exp[TAG_W], exp[TAG_W-1:0]);
      end
    end
    cyc();
  endtask

  // ---------------------------------------------------------------------------
`ifdef BR_COND_ARB_PERF_EN
  task automatic test_perf();
    logic [TAG_W+1:0] exp;
    cyc();
    reset = 1'b1;
    idle_reqs();
    cyc();
    reset = 1'b0;
    bus.io_resp_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i < 10) begin
        // first six equal (taken), last four unequal (not taken)
        drive_req(0, 1'b1, 32'(i), (i < 6) ? 32'(i) : 32'(i + 1), 3'd3, 4'(i));
        sb.push_back({(i < 6) ? 1'b1 : 1'b0, 1'b0, 4'(i)});
      end else begin
        idle_reqs();
      end
      mid();
      if (i > 0) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL perf_sb[%0d]: scoreboard empty", i);
        end else begin
          exp = sb.pop_front();
          if ({bus.io_resp_valid, bus.io_resp_taken, bus.io_resp_tag}
              !== {1'b1, exp[TAG_W+1], exp[TAG_W-1:0]}) begin
            bad++;
            $display("FAIL perf_resp[%0d]: got v=%b t=%b tag=%h expected v=1 t=%b tag=%h",
                     i, bus.io_resp_valid, bus.io_resp_taken, bus.io_resp_tag,
                     exp[TAG_W+1], exp[TAG_W-1:0]);
          end
        end
      end
      cyc();
    end
    mid();
    total++;
    if (perf_branches !== 32'd10) begin
      bad++;
      $display("FAIL perf_branches: got %0d expected 10", perf_branches);
    end
    total++;
    if (perf_taken !== 32'd6) begin
      bad++;
      $display("FAIL perf_taken: got %0d expected 6", perf_taken);
    end
    cyc();
  endtask
`endif

  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    bus.io_resp_ready = 1'b0;
    drive_req(0, 1'b0, 32'd0, 32'd0, 3'd0, '0);
    drive_req(1, 1'b0, 32'd0, 32'd0, 3'd0, '0);
    test_reset();
    test_single();
    test_compare();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
`ifdef BR_COND_ARB_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
